// File: rtl/bcd_pkg.sv
// Shared types for the BCD stopwatch: FSM states and the BCD digit type.
// Lap-hold display feature is compiled in with BCD_LAP_HOLD_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with increment, forced wrap and carry out.
// Carry is combinational so a chained digit advances on the same edge.
import bcd_pkg::*;

module bcd_digit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic wrap,
  output bcd_t digit,
  output logic carry
);

  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    carry   = 1'b0;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      if (wrap) begin
        digit_d = '0;
      end else if (digit_q >= BCD_MAX_DIGIT) begin
        digit_d = '0;
        carry   = 1'b1;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Two-digit BCD stopwatch: start/pause FSM, prescaler, chained digits.
// Define BCD_LAP_HOLD_EN to compile in the lap display hold.
import bcd_pkg::*;

module bcd_stopwatch #(
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam bcd_t MAX_ONES = bcd_t'(MAX_COUNT % 10);
  localparam bcd_t MAX_TENS = bcd_t'(MAX_COUNT / 10);

  state_e        state_q, state_d;
  logic          ss_prev_q, ss_prev_d;
  logic          ss_edge;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;

  bcd_t ones_live, tens_live;
  logic ones_carry;
  logic unused_tens_carry;
  logic at_max;

  always_comb begin
    ss_prev_d = start_stop;
    ss_edge   = start_stop & ~ss_prev_q;
    state_d   = state_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;

    // clear wins over a simultaneous start_stop edge
    unique case (state_q)
      IDLE:    if (!clear && ss_edge) state_d = RUN;
      RUN:     if (!clear && ss_edge) state_d = PAUSE;
      PAUSE: begin
        if (clear)        state_d = IDLE;
        else if (ss_edge) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ss_prev_q <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_prev_q <= ss_prev_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign at_max = (ones_live == MAX_ONES) &&
                  (tens_live == MAX_TENS);

  bcd_digit u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (tick_d),
    .wrap  (at_max),
    .digit (ones_live),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (ones_carry | (tick_d & at_max)),
    .wrap  (at_max),
    .digit (tens_live),
    .carry (unused_tens_carry)
  );

  assign running = running_q;
  assign tick    = tick_q;

`ifdef BCD_LAP_HOLD_EN
  logic lap_prev_q, lap_prev_d;
  logic lap_edge;
  logic hold_q, hold_d;
  bcd_t lap_ones_q, lap_ones_d;
  bcd_t lap_tens_q, lap_tens_d;

  always_comb begin
    lap_prev_d = lap;
    lap_edge   = lap & ~lap_prev_q;
    hold_d     = hold_q;
    lap_ones_d = lap_ones_q;
    lap_tens_d = lap_tens_q;
    if (clear || state_d == IDLE) begin
      hold_d = 1'b0;
    end else if (state_q == RUN && lap_edge) begin
      hold_d = ~hold_q;
      if (!hold_q) begin
        lap_ones_d = ones_live;
        lap_tens_d = tens_live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_prev_q <= 1'b0;
      hold_q     <= 1'b0;
      lap_ones_q <= '0;
      lap_tens_q <= '0;
    end else begin
      lap_prev_q <= lap_prev_d;
      hold_q     <= hold_d;
      lap_ones_q <= lap_ones_d;
      lap_tens_q <= lap_tens_d;
    end
  end

  assign ones = hold_q ? lap_ones_q : ones_live;
  assign tens = hold_q ? lap_tens_q : tens_live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign ones = ones_live;
  assign tens = tens_live;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: table of scenario rows plus a per-cycle
// scoreboard fed by a behavioural count model (MAX_COUNT 59 and 9).
module tb_bcd_stopwatch;

  localparam int TD = 4;
`ifdef BCD_LAP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [3:0] a_ones, a_tens, b_ones, b_tens;
  logic       a_run, a_tick, b_run, b_tick;

  always #5 clk = ~clk;

  bcd_stopwatch #(.TICK_DIV(TD), .MAX_COUNT(59)) dut_a (
    .clk(clk), .rst(rst), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .ones(a_ones), .tens(a_tens),
    .running(a_run), .tick(a_tick)
  );

  bcd_stopwatch #(.TICK_DIV(TD), .MAX_COUNT(9)) dut_b (
    .clk(clk), .rst(rst), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .ones(b_ones), .tens(b_tens),
    .running(b_run), .tick(b_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, index 0 = MAX 59, index 1 = MAX 9
  int m_max[2]  = '{59, 9};
  int m_st[2]   = '{0, 0};
  int m_pre[2]  = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_held[2] = '{0, 0};
  bit m_tick[2] = '{0, 0};
  bit m_pss[2]  = '{0, 0};
  bit m_plap[2] = '{0, 0};
  bit m_hold[2] = '{0, 0};

  logic [19:0] exp_q[$];

  task automatic model_step(input int k, input bit s, input bit c,
                            input bit l, input bit r);
    bit sse, lape;
    int old;
    if (r) begin
      m_st[k] = 0; m_pre[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
      m_pss[k] = 0; m_plap[k] = 0; m_hold[k] = 0;
    end else begin
      sse = s && !m_pss[k];
      lape = l && !m_plap[k];
      m_pss[k] = s;
      m_plap[k] = l;
      m_tick[k] = 0;
      old = m_cnt[k];
      if (c) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_hold[k] = 0;
        if (m_st[k] == 2) m_st[k] = 0;
      end else begin
        if (m_st[k] == 1) begin
          if (m_pre[k] == TD - 1) begin
            m_pre[k] = 0;
            m_tick[k] = 1;
            m_cnt[k] = (m_cnt[k] == m_max[k]) ? 0 : m_cnt[k] + 1;
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
          if (HOLD && lape) begin
            if (m_hold[k]) m_hold[k] = 0;
            else begin m_hold[k] = 1; m_held[k] = old; end
          end
        end
        if (sse) m_st[k] = (m_st[k] == 1) ? 2 : 1;
      end
    end
  endtask

  function automatic logic [9:0] model_out(input int k);
    int d;
    d = m_hold[k] ? m_held[k] : m_cnt[k];
    return {4'(d % 10), 4'(d / 10), m_st[k] == 1, m_tick[k]};
  endfunction

  task automatic step(input bit s, input bit c, input bit l, input bit r);
    logic [19:0] exp_v, got;
    @(negedge clk);
    start_stop = s; clear = c; lap = l; rst = r;
    model_step(0, s, c, l, r);
    model_step(1, s, c, l, r);
    exp_q.push_back({model_out(0), model_out(1)});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got = {a_ones, a_tens, a_run, a_tick, b_ones, b_tens, b_run, b_tick};
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL cycle t=%0t outputs got %h exp %h", $time, got, exp_v);
    end
  endtask

  typedef struct {
    bit ss, clr, lp, rs;
    int n;
    logic [3:0] ones, tens;
    logic run, tck;
    logic [3:0] b_ones;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit c, input bit l, input bit r,
                     input int n, input int o, input int t,
                     input bit ru, input bit tk, input int bo);
    vec_t v;
    v.ss = s; v.clr = c; v.lp = l; v.rs = r; v.n = n;
    v.ones = 4'(o); v.tens = 4'(t); v.run = ru; v.tck = tk;
    v.b_ones = 4'(bo);
    tbl.push_back(v);
  endtask

  initial begin
    //  ss clr lap rst  n   ones tens run tick b_ones
    add(0, 0, 0, 1,   2,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   1,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0,  48,  2, 1, 1, 1, 2);
    add(0, 0, 0, 0, 100,  7, 3, 1, 1, 7);
    add(1, 0, 1, 1,   2,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0,   1,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   1,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 236,  9, 5, 1, 1, 9);
    add(0, 0, 0, 0,   4,  0, 0, 1, 1, 0);
    add(0, 0, 0, 0,  20,  5, 0, 1, 1, 5);
    add(0, 0, 0, 0,   1,  5, 0, 1, 0, 5);
    add(1, 0, 0, 0,   5,  5, 0, 0, 0, 5);
    add(0, 0, 0, 0,  16,  5, 0, 0, 0, 5);
    add(1, 0, 0, 0,   1,  5, 0, 1, 0, 5);
    add(0, 0, 0, 0,   1,  5, 0, 1, 0, 5);
    add(0, 0, 0, 0,   1,  6, 0, 1, 1, 6);
    add(0, 0, 0, 0,  76,  5, 2, 1, 1, 5);
    add(1, 0, 0, 0,   1,  5, 2, 0, 0, 5);
    add(0, 0, 0, 0,   2,  5, 2, 0, 0, 5);
    add(1, 1, 0, 0,   1,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0,   2,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   1,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0,   6,  1, 0, 1, 0, 1);
    add(0, 1, 0, 0,   1,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0,   4,  1, 0, 1, 1, 1);
    add(0, 0, 0, 0,  52,  4, 1, 1, 1, 4);
    add(0, 0, 0, 0,   1,  4, 1, 1, 0, 4);
    add(0, 0, 1, 0,   1,  4, 1, 1, 0, 4);
    add(0, 0, 0, 0,  18,  HOLD ? 4 : 9, 1, 1, 1, HOLD ? 4 : 9);
    add(0, 0, 1, 0,   1,  9, 1, 1, 0, 9);
    add(0, 0, 0, 0,   3,  0, 2, 1, 1, 0);

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].ss, tbl[i].clr, tbl[i].lp, tbl[i].rs);
      n_tests++;
      if ({a_ones, a_tens, a_run, a_tick} !==
          {tbl[i].ones, tbl[i].tens, tbl[i].run, tbl[i].tck}) begin
        n_fail++;
        $display("FAIL row%0d A ones/tens/run/tick got %0d %0d %0b %0b exp %0d %0d %0b %0b",
                 i, a_ones, a_tens, a_run, a_tick,
                 tbl[i].ones, tbl[i].tens, tbl[i].run, tbl[i].tck);
      end
      n_tests++;
      if ({b_ones, b_tens} !== {tbl[i].b_ones, 4'd0}) begin
        n_fail++;
        $display("FAIL row%0d B (max9) ones/tens got %0d %0d exp %0d 0",
                 i, b_ones, b_tens, tbl[i].b_ones);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per count increment, minimum 2.
REQ-002 SHALL have parameter MAX_COUNT, default 59: last value before wrap to 00, range 1..99.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start_stop, input, 1: debounced button level; each rising edge toggles run/pause.
REQ-006 SHALL have port clear, input, 1: level; zeroes the count in any state.
REQ-007 SHALL have port lap, input, 1: debounced button level for the display hold; ignored unless BCD_LAP_HOLD_EN is defined.
REQ-008 SHALL have port ones, output, 4: BCD ones digit that feeds the 7-segment decoder Number input.
REQ-009 SHALL have port tens, output, 4: BCD tens digit that feeds a second 7-segment decoder.
REQ-010 SHALL have port running, output, 1: high while in RUN.
REQ-011 SHALL have port tick, output, 1: one-cycle pulse on every count increment.

Function
REQ-012 SHALL detect rising edges of start_stop and lap with a one-cycle registered delay; a level held high produces exactly one edge.
REQ-013 SHALL implement the FSM states IDLE, RUN and PAUSE: IDLE->RUN, RUN->PAUSE and PAUSE->RUN each on a start_stop edge.
REQ-014 SHALL return from PAUSE to IDLE when clear is high; clear in RUN zeroes the digits and the prescaler but stays in RUN.
REQ-015 SHALL give clear priority when clear and a start_stop edge occur in the same cycle: the digits zero and the edge is discarded.
REQ-016 SHALL run the prescaler only in RUN: count 0..TICK_DIV-1, and at TICK_DIV-1 reload 0, assert tick and increment the count on that same edge.
REQ-017 SHALL hold the prescaler value in PAUSE, so that a resume completes the partial period.
REQ-018 SHALL increment the count in BCD: ones 9->0 with a carry into tens; a count equal to MAX_COUNT goes to 00.
REQ-019 SHALL keep ones and tens within 0..9 at all times.
REQ-020 SHALL drive every output from a register, with no combinational path from any input to any output.
REQ-021 SHALL update the digits on the edge that asserts tick, so the 7-segment stage sees the new value one cycle later.

Reset
REQ-022 SHALL on rst=1 at a clk edge set the state to IDLE, ones=0, tens=0, running=0, tick=0, prescaler=0, edge registers=0 and hold=0.
REQ-023 SHALL let rst override clear, start_stop and lap, including in the middle of a prescaler period.

Configuration
REQ-024 SHALL use the macro BCD_LAP_HOLD_EN to compile the lap-hold feature in or out.
REQ-025 SHALL, with BCD_LAP_HOLD_EN defined, toggle hold on each lap edge in RUN; while hold is set, ones and tens show the count captured at the edge, while the internal count and tick continue.
REQ-026 SHALL, with BCD_LAP_HOLD_EN defined, clear hold on clear, rst, or a transition to IDLE, and ignore lap edges in IDLE and PAUSE.
REQ-027 SHALL, without BCD_LAP_HOLD_EN, ignore lap, contain no hold logic, and drive the outputs from the live count at all times.

Structure
REQ-028 SHALL use the shared package bcd_pkg for the state enum (IDLE/RUN/PAUSE), the 4-bit BCD digit typedef and the constant BCD_MAX_DIGIT=9.
REQ-029 SHALL build each digit from one instance of the sub-module bcd_digit (inputs clk, rst, clr, inc, wrap; outputs digit, carry), with two instances chained ones->tens.

Verification (TICK_DIV=4, MAX_COUNT=59 unless stated)
REQ-030 SHALL verify reset: assert rst for 2 cycles in RUN at count 37 -> next cycle ones=0, tens=0, running=0, tick=0.
REQ-031 SHALL verify start and timing: a start_stop pulse from IDLE -> running=1; tick every 4 cycles; after 12 ticks tens=1 and ones=2.
REQ-032 SHALL verify wrap: run to 59 and take one more tick -> tens=0 and ones=0; with MAX_COUNT=9 the sequence runs 9->0 and tens stays 0.
REQ-033 SHALL verify pause: pause at prescaler value 2 for 20 cycles, then resume -> the next tick arrives 2 cycles after resume and the count is unchanged across the pause.
REQ-034 SHALL verify simultaneous clear and start_stop edge in PAUSE at 25 -> digits 00, state IDLE, running=0.
REQ-035 SHALL verify lap hold with BCD_LAP_HOLD_EN: lap at 14, run 5 ticks -> outputs read 14; a second lap -> outputs read 19; without the macro, lap has no effect.
